// File: rtl/uart_challenge_rx.sv
// -----------------------------------------------------------------------------
// uart_challenge_rx
// Receive front end for the challenge/response UART path. Deframes 8N1 bytes
// from the asynchronous uart_rx line and packs Challenge_Bit/8 consecutive good
// bytes into one challenge word (first byte received lands in the MSBs).
//
// Ports:
//   clk              in   system clock, all logic on the rising edge
//   rst              in   asynchronous active-high reset
//   uart_rx          in   serial line, idles high
//   rx_byte          out  last good byte received
//   rx_byte_valid    out  1-cycle pulse, rx_byte updated this cycle
//   frame_error      out  1-cycle pulse on a bad stop bit
//   challenge        out  last complete challenge word
//   challenge_valid  out  1-cycle pulse, challenge updated this cycle
//   busy             out  high whenever the receiver FSM is not idle
// -----------------------------------------------------------------------------
module uart_challenge_rx #(
    parameter int CLK_FRE       = 16,
    parameter int BAUD_RATE     = 115200,
    parameter int Challenge_Bit = 8,
    parameter int TIMEOUT_BITS  = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     uart_rx,
    output logic [7:0]               rx_byte,
    output logic                     rx_byte_valid,
    output logic                     frame_error,
    output logic [Challenge_Bit-1:0] challenge,
    output logic                     challenge_valid,
    output logic                     busy
);

    localparam int CYCLE       = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int HALF        = CYCLE / 2;
    localparam int CNT_W       = $clog2(CYCLE);
    localparam int N_BYTES     = Challenge_Bit / 8;
    localparam int BC_W        = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int TIMEOUT_CYC = TIMEOUT_BITS * CYCLE;
    localparam int IDLE_W      = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                   state_q, state_d;
    logic                     rx_meta_q, rx_meta_d;
    logic                     rxs_q, rxs_d;
    logic                     rxs_prev_q, rxs_prev_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [2:0]               bit_idx_q, bit_idx_d;
    logic [7:0]               shift_q, shift_d;
    logic [7:0]               rx_byte_q, rx_byte_d;
    logic                     rx_byte_valid_q, rx_byte_valid_d;
    logic                     frame_error_q, frame_error_d;
    logic [Challenge_Bit-1:0] acc_q, acc_d;
    logic [BC_W-1:0]          bc_q, bc_d;
    logic [Challenge_Bit-1:0] challenge_q, challenge_d;
    logic                     challenge_valid_q, challenge_valid_d;
    logic [IDLE_W-1:0]        idle_cnt_q, idle_cnt_d;
    logic                     busy_q, busy_d;

    logic                     fall;
    logic                     good_byte;
    logic                     bad_byte;
    logic [Challenge_Bit-1:0] acc_shift;

    // Falling edge of the synchronized line starts a frame.
    assign fall = rxs_prev_q & ~rxs_q;

    // Shift the new byte in at the bottom; truncating the concatenation drops
    // the oldest byte (for a one-byte challenge this is just the byte itself).
    assign acc_shift = Challenge_Bit'({acc_q, shift_q});

    always_comb begin
        rx_meta_d         = uart_rx;
        rxs_d             = rx_meta_q;
        rxs_prev_d        = rxs_q;
        state_d           = state_q;
        cnt_d             = cnt_q + 1'b1;
        bit_idx_d         = bit_idx_q;
        shift_d           = shift_q;
        rx_byte_d         = rx_byte_q;
        rx_byte_valid_d   = 1'b0;
        frame_error_d     = 1'b0;
        acc_d             = acc_q;
        bc_d              = bc_q;
        challenge_d       = challenge_q;
        challenge_valid_d = 1'b0;
        idle_cnt_d        = '0;
        good_byte         = 1'b0;
        bad_byte          = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // Mid-start check: a line already back high was a glitch.
                if (cnt_q == CNT_W'(HALF - 1)) begin
                    cnt_d = '0;
                    if (!rxs_q) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_W'(CYCLE - 1)) begin
                    cnt_d     = '0;
                    shift_d   = {rxs_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                // Leaving at mid-stop keeps the next start edge visible.
                if (cnt_q == CNT_W'(CYCLE - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rxs_q) begin
                        rx_byte_d       = shift_q;
                        rx_byte_valid_d = 1'b1;
                        good_byte       = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                        bad_byte      = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Challenge assembler.
        if (good_byte) begin
            acc_d = acc_shift;
            if (bc_q == BC_W'(N_BYTES - 1)) begin
                challenge_d       = acc_shift;
                challenge_valid_d = 1'b1;
                bc_d              = '0;
            end else begin
                bc_d = bc_q + 1'b1;
            end
        end else if (bad_byte) begin
            acc_d = '0;
            bc_d  = '0;
        end

        // A partial challenge left idle too long is thrown away.
        if (state_q == S_IDLE && bc_q != '0 && state_d == S_IDLE) begin
            if (idle_cnt_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
                acc_d = '0;
                bc_d  = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q         <= 1'b1;
            rxs_q             <= 1'b1;
            rxs_prev_q        <= 1'b1;
            state_q           <= S_IDLE;
            cnt_q             <= '0;
            bit_idx_q         <= '0;
            shift_q           <= '0;
            rx_byte_q         <= '0;
            rx_byte_valid_q   <= 1'b0;
            frame_error_q     <= 1'b0;
            acc_q             <= '0;
            bc_q              <= '0;
            challenge_q       <= '0;
            challenge_valid_q <= 1'b0;
            idle_cnt_q        <= '0;
            busy_q            <= 1'b0;
        end else begin
            rx_meta_q         <= rx_meta_d;
            rxs_q             <= rxs_d;
            rxs_prev_q        <= rxs_prev_d;
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            bit_idx_q         <= bit_idx_d;
            shift_q           <= shift_d;
            rx_byte_q         <= rx_byte_d;
            rx_byte_valid_q   <= rx_byte_valid_d;
            frame_error_q     <= frame_error_d;
            acc_q             <= acc_d;
            bc_q              <= bc_d;
            challenge_q       <= challenge_d;
            challenge_valid_q <= challenge_valid_d;
            idle_cnt_q        <= idle_cnt_d;
            busy_q            <= busy_d;
        end
    end

    assign rx_byte         = rx_byte_q;
    assign rx_byte_valid   = rx_byte_valid_q;
    assign frame_error     = frame_error_q;
    assign challenge       = challenge_q;
    assign challenge_valid = challenge_valid_q;
    assign busy            = busy_q;

endmodule

// File: doc/uart_challenge_rx.md
# uart_challenge_rx

Receive front end for the challenge/response UART path. It samples the asynchronous `uart_rx` line at `CLK_FRE` MHz and deframes 8N1 bytes. It assembles consecutive bytes into one `Challenge_Bit`-wide challenge word and presents that word, with a one-cycle strobe, to the challenge/response core that generates `uart_tx`.

## Interface
Parameters:
- `CLK_FRE`, 16: system clock frequency in MHz.
- `BAUD_RATE`, 115200: line rate in bit/s.
- `Challenge_Bit`, 8: challenge width. Must be a multiple of 8 and at least 8. N = `Challenge_Bit`/8 bytes per challenge.
- `TIMEOUT_BITS`, 20: idle bit-times after which a partially assembled challenge is discarded.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `uart_rx`  in  1  serial input; idles high.
- `rx_byte`  out  8  last good byte received.
- `rx_byte_valid`  out  1  one-cycle pulse; `rx_byte` updated this cycle.
- `frame_error`  out  1  one-cycle pulse on a bad stop bit.
- `challenge`  out  `Challenge_Bit`  last complete challenge word.
- `challenge_valid`  out  1  one-cycle pulse; `challenge` updated this cycle.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Constants: CYCLE = CLK_FRE*1000000/BAUD_RATE, using integer division (16 MHz / 115200 gives 138). HALF = CYCLE/2 (69).
- Synchronizer: a 2-FF chain on `uart_rx`, both flops resetting to 1. A previous-value flop, also resetting to 1, provides falling-edge detection on the synchronized signal `rxs`.
- Bit counter: `cnt`, clog2(CYCLE) bits wide, cleared on every state entry.
- IDLE: on a falling edge of `rxs`, go to START.
- START: when `cnt` == HALF-1, sample `rxs`. If it is 0, go to DATA with bit index 0. If it is 1, treat it as a glitch and return to IDLE with no output.
- DATA: when `cnt` == CYCLE-1, sample `rxs` into the shift register LSB-first and increment the bit index. After bit 7 is sampled, go to STOP.
- STOP: when `cnt` == CYCLE-1, sample `rxs`, then go to IDLE. Sampling at mid-stop lets the next start edge be caught.
  - Stop = 1: load `rx_byte` and pulse `rx_byte_valid`.
  - Stop = 0: pulse `frame_error`, leave `rx_byte` unchanged, and clear the assembler.
- Assembler:
  - Holds a byte count `bc` (0..N-1) and an accumulator.
  - On each good byte: acc = {acc[Challenge_Bit-9:0], byte}, so the first byte received ends in the MSB position.
  - When `bc` == N-1, in the same cycle: load `challenge` with the completed value, pulse `challenge_valid`, and set `bc` to 0. Otherwise increment `bc`.
  - N = 1: every good byte is a challenge.
- Timeout:
  - An idle counter runs only while in IDLE with `bc` != 0.
  - When it reaches TIMEOUT_BITS*CYCLE cycles, clear `bc` and the accumulator.
  - The counter clears on leaving IDLE.
- `challenge` holds its value until the next completion. It is not cleared by a frame error or a timeout.

## Timing
- Reset values: `rx_byte` = 0, `rx_byte_valid` = 0, `frame_error` = 0, `challenge` = 0, `challenge_valid` = 0, `busy` = 0. FSM in IDLE, `bc` = 0, accumulator = 0.
- Reset mid-frame aborts immediately. After release, the block waits for a fresh falling edge; a line that is already low does not start a frame.
- Latency, `uart_rx` falling edge to START entry: 3 cycles (2 synchronizer cycles plus edge detect).
- The stop-bit sample lands about 9.5 bit-times after the start edge. `rx_byte_valid`, `frame_error` and `challenge_valid` are registered and assert on the cycle after the stop sample.
- `challenge_valid` is coincident with the `rx_byte_valid` of the Nth byte.
- Output pulses are exactly 1 cycle. There is no back-pressure; the consumer must accept the pulse.
- Back-to-back frames with no idle gap are received without loss.
- A start bit shorter than HALF cycles is rejected.

## Test plan
All scenarios use CLK_FRE=16 and BAUD_RATE=115200, i.e. 138 cycles per bit.
- Single byte, `Challenge_Bit`=8: send 0xA5 -> one `rx_byte_valid` with `rx_byte`=0xA5; `challenge`=0xA5 with a coincident `challenge_valid`; `busy` falls back to 0.
- Multi-byte, `Challenge_Bit`=16: send 0x12 then 0x34 back-to-back -> two `rx_byte_valid` pulses; a single `challenge_valid`, on the second, with `challenge`=0x1234.
- Framing error, `Challenge_Bit`=16: send 0x12, then 0x34 with stop=0, then 0x56 and 0x78 -> `frame_error` pulses once; the only challenge is 0x5678.
- Glitch: a 30-cycle low pulse on `uart_rx` -> START is entered then abandoned; no `rx_byte_valid`, no `frame_error`, `busy` low again within 75 cycles.
- Timeout, `Challenge_Bit`=16: send 0x12, idle 25 bit-times, send 0x34 and 0x56 -> `challenge`=0x3456; 0x12 is discarded.
- Reset mid-frame: assert `rst` during bit 3 of 0xFF, release, send 0x3C -> all outputs at reset values during reset; exactly one `rx_byte_valid` afterwards, with 0x3C.
